hslp_seq_ctrl: RTL

HSLP_SEQ_CTRL -- requirements
Module: hslp_seq_ctrl

---
 rtl/hslp_seq_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/hslp_seq_ctrl.sv
// hslp_seq_ctrl: 8x8 approximate multiplier built from four passes through a
// shared 4x4 nibble multiplier. Each nibble step drives the shared unit for
// one cycle and accumulates its shifted partial product into a 16-bit acc.
//
// state | meaning
// ------+--------------------------------------------------------
// IDLE  | waiting for an operand pair, in_ready high
// LL    | a[3:0] x b[3:0], shift 0
// LH    | a[3:0] x b[7:4], shift 4
// HL    | a[7:4] x b[3:0], shift 4
// HH    | a[7:4] x b[7:4], shift 8
// DONE  | result on prod, out_valid high until out_ready
module hslp_seq_ctrl #(
  parameter logic [1:0] SEL_LL = 2'd3,
  parameter logic [1:0] SEL_LH = 2'd3,
  parameter logic [1:0] SEL_HL = 2'd1,
  parameter logic [1:0] SEL_HH = 2'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] prod,
  output logic        busy,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  output logic [1:0]  mul_sel,
  input  logic [7:0]  mul_prod
);

  typedef enum logic [2:0] {
    S_IDLE, S_LL, S_LH, S_HL, S_HH, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  a_q, b_q;
  logic [15:0] acc;
  logic [3:0]  shift;
  logic        acc_en;
  logic        accept;

  assign accept = in_valid & in_ready;
  assign prod   = acc;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state, handshake and nibble-operand selection from the current state.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    mul_a     = 4'd0;
    mul_b     = 4'd0;
    mul_sel   = SEL_LL;
    shift     = 4'd0;
    acc_en    = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = S_LL;
      end
      S_LL: begin
        mul_a = a_q[3:0]; mul_b = b_q[3:0]; mul_sel = SEL_LL;
        shift = 4'd0; acc_en = 1'b1; state_nxt = S_LH;
      end
      S_LH: begin
        mul_a = a_q[3:0]; mul_b = b_q[7:4]; mul_sel = SEL_LH;
        shift = 4'd4; acc_en = 1'b1; state_nxt = S_HL;
      end
      S_HL: begin
        mul_a = a_q[7:4]; mul_b = b_q[3:0]; mul_sel = SEL_HL;
        shift = 4'd4; acc_en = 1'b1; state_nxt = S_HH;
      end
      S_HH: begin
        mul_a = a_q[7:4]; mul_b = b_q[7:4]; mul_sel = SEL_HH;
        shift = 4'd8; acc_en = 1'b1; state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        // Leaving DONE lands in IDLE; acceptance needs a further edge.
        if (out_ready) state_nxt = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand latch on acceptance and modulo-2^16 accumulation of partial products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= 8'd0;
      b_q <= 8'd0;
      acc <= 16'd0;
    end else if (accept) begin
      a_q <= a;
      b_q <= b;
      acc <= 16'd0;
    end else if (acc_en) begin
      acc <= acc + (16'(mul_prod) << shift);
    end
  end

endmodule
